isp_restart_seq: RTL and testbench
==================================

Name: isp_restart_seq

Overview:
- Parametrised successor to the post-ISP device restart block.
- Accepts NUM_SRC restart request channels, e.g. MSS ISP-complete GPIO, watchdog, or a UART-commanded reboot.
- Each channel has its own enable mask. A request is honoured only when the sequencer is armed.
- After a programmable delay, drives a fixed-width active-low restart pulse, then waits a holdoff period during which new requests are ignored.
- Sits in the fabric beside the MSS. Clocked from MCCC_CLK_BASE and reset by MSS_RESET_N_M2F.

Parameters:
- NUM_SRC, 4, number of restart request channels (1..8).
- CNT_W, 16, width of the delay counter and of DELAY_VAL/COUNT.
- DEFAULT_DELAY, 20, delay in cycles used when DELAY_VAL==0. Must fit in CNT_W.
- PULSE_CYCLES, 8, cycles RESTART_N is held low (>=1).
- HOLDOFF_CYCLES, 16, cycles after the pulse during which requests are ignored (>=1).

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESETn  in  1  asynchronous active-low reset.
- ARM  in  1  level; enables request acceptance.
- CANCEL  in  1  level; aborts a pending delay.
- SRC_REQ  in  NUM_SRC  restart requests, synchronous to CLK. Only the rising edge is used.
- SRC_MASK  in  NUM_SRC  1 = channel enabled.
- DELAY_VAL  in  CNT_W  runtime delay. 0 selects DEFAULT_DELAY.
- RESTART_N  out  1  registered active-low restart pulse.
- BUSY  out  1  high in DELAY, ASSERT and HOLDOFF.
- COUNT  out  CNT_W  remaining delay cycles in DELAY, else 0.
- SRC_LATCHED  out  NUM_SRC  channels that requested in the current sequence.

Behaviour:
- Reset (async, RESETn low):
  - state=IDLE, RESTART_N=1, BUSY=0, COUNT=0, SRC_LATCHED=0, edge-detect registers=0.
  - Reset in ASSERT releases RESTART_N to 1 immediately, without waiting for a clock edge.
- Edge detect: req_q <= SRC_REQ each cycle. hit = SRC_REQ & ~req_q & SRC_MASK. A level held high gives one hit only.
- States: IDLE, ARMED, DELAY, ASSERT, HOLDOFF. All outputs are registered.
- IDLE:
  - ARM=1 -> ARMED.
  - Hits are discarded.
- ARMED:
  - ARM=0 -> IDLE.
  - Else, if CANCEL=0 and hit!=0 -> DELAY.
  - On entry to DELAY: COUNT <= (DELAY_VAL==0 ? DEFAULT_DELAY : DELAY_VAL), SRC_LATCHED <= hit.
  - CANCEL=1 in the same cycle as a hit suppresses that hit; it is lost, not queued.
- DELAY:
  - CANCEL=1 or ARM=0 -> ARMED if ARM=1, else IDLE. SRC_LATCHED<=0, COUNT<=0.
  - Else if COUNT==0 -> ASSERT.
  - Else COUNT<=COUNT-1.
  - Further hits OR into SRC_LATCHED and do not reload COUNT.
  - With effective delay D, DELAY lasts D+1 cycles. RESTART_N is low from D+1 cycles after the first DELAY cycle.
  - DELAY_VAL is sampled only on entry. Later changes have no effect.
  - DELAY_VAL=1 behaves as D=1; D is never 0.
- ASSERT:
  - RESTART_N=0 for exactly PULSE_CYCLES cycles, using an internal pulse counter.
  - CANCEL, ARM and hits are ignored; the pulse is never truncated except by reset.
  - Then -> HOLDOFF.
- HOLDOFF:
  - RESTART_N=1 for HOLDOFF_CYCLES cycles. Hits are discarded.
  - At exit: SRC_LATCHED<=0; next state ARMED if ARM=1, else IDLE.
  - SRC_LATCHED stays valid through ASSERT and HOLDOFF so software can read the cause.
- Internal counter width is clog2(max(PULSE_CYCLES,HOLDOFF_CYCLES)+1). Counters never wrap.

Test Plan:
- Reset, then ARM=1, SRC_MASK=4'b0001, DELAY_VAL=0; pulse SRC_REQ[0] one cycle.
  - DELAY entered with COUNT=20, counting to 0.
  - RESTART_N low exactly 8 cycles, starting 21 cycles after DELAY entry.
  - BUSY high DELAY through HOLDOFF, then ARMED.
- SRC_MASK=4'b0010, SRC_REQ=4'b0001 pulse -> no transition, RESTART_N stays 1.
  - Then SRC_REQ[1] held high 50 cycles -> exactly one sequence, SRC_LATCHED=4'b0010.
- DELAY_VAL=5, hit ch0; at COUNT=3 assert CANCEL -> back to ARMED, COUNT=0, SRC_LATCHED=0, no pulse.
  - Repeat with ARM dropped instead -> IDLE.
- DELAY_VAL=10, hit ch0, then hit ch2 at COUNT=6 -> COUNT not reloaded, pulse at the original time, SRC_LATCHED=4'b0101.
- During ASSERT toggle CANCEL, ARM=0 and hits -> pulse still 8 cycles. Hits during HOLDOFF do not start a new sequence.
  - Then IDLE, because ARM=0.
- Drop RESETn asynchronously at the 3rd ASSERT cycle -> RESTART_N=1 before the next CLK edge, all outputs at reset values.
  - After release, state is IDLE and ARM must be re-asserted.

Source files
------------

// File: rtl/isp_restart_seq.sv
// Restart sequencer: masked, edge-detected restart requests start a
// delay, then a fixed-width active-low RESTART_N pulse and a holdoff.
module isp_restart_seq #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEFAULT_DELAY  = 20,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned HOLDOFF_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               ARM,
  input  logic               CANCEL,
  input  logic [NUM_SRC-1:0] SRC_REQ,
  input  logic [NUM_SRC-1:0] SRC_MASK,
  input  logic [CNT_W-1:0]   DELAY_VAL,
  output logic               RESTART_N,
  output logic               BUSY,
  output logic [CNT_W-1:0]   COUNT,
  output logic [NUM_SRC-1:0] SRC_LATCHED
);

  localparam int unsigned MAX_PH = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned PH_W   = $clog2(MAX_PH + 1);

  localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEF_DELAY  = CNT_W'(DEFAULT_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_ASSERT,
    S_HOLDOFF
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] hit;
  logic [PH_W-1:0]    ph_cnt;
  logic [CNT_W-1:0]   eff_delay;

  assign hit       = SRC_REQ & ~req_q & SRC_MASK;
  assign eff_delay = (DELAY_VAL == '0) ? DEF_DELAY : DELAY_VAL;

  // NOTE: the async reset term forces RESTART_N high the moment RESETn
  // falls, so a pulse in flight is released without waiting for CLK.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      req_q       <= '0;
      ph_cnt      <= '0;
      RESTART_N   <= 1'b1;
      BUSY        <= 1'b0;
      COUNT       <= '0;
      SRC_LATCHED <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the
      // pre-edge values of its peers, independent of statement order.
      req_q <= SRC_REQ;
      case (state)
        S_IDLE: begin
          if (ARM) state <= S_ARMED;
        end

        S_ARMED: begin
          if (!ARM) begin
            state <= S_IDLE;
          end else if (!CANCEL && (hit != '0)) begin
            state       <= S_DELAY;
            BUSY        <= 1'b1;
            COUNT       <= eff_delay;
            SRC_LATCHED <= hit;
          end
        end

        S_DELAY: begin
          if (CANCEL || !ARM) begin
            state       <= ARM ? S_ARMED : S_IDLE;
            BUSY        <= 1'b0;
            COUNT       <= '0;
            SRC_LATCHED <= '0;
          end else begin
            // Late requests are recorded as causes but never restart the delay.
            SRC_LATCHED <= SRC_LATCHED | hit;
            if (COUNT == '0) begin
              state     <= S_ASSERT;
              RESTART_N <= 1'b0;
              ph_cnt    <= '0;
            end else begin
              COUNT <= COUNT - CNT_W'(1);
            end
          end
        end

        S_ASSERT: begin
          if (ph_cnt == PULSE_LAST) begin
            state     <= S_HOLDOFF;
            RESTART_N <= 1'b1;
            ph_cnt    <= '0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        S_HOLDOFF: begin
          if (ph_cnt == HOLD_LAST) begin
            state       <= ARM ? S_ARMED : S_IDLE;
            BUSY        <= 1'b0;
            SRC_LATCHED <= '0;
            ph_cnt      <= '0;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end

        default: begin
          state       <= S_IDLE;
          ph_cnt      <= '0;
          RESTART_N   <= 1'b1;
          BUSY        <= 1'b0;
          COUNT       <= '0;
          SRC_LATCHED <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isp_restart_seq.sv
// Directed bench for isp_restart_seq: a per-cycle vector table plus
// hand-written sequences for the multi-cycle corner cases.
module tb_isp_restart_seq;

  localparam int NS = 4;
  localparam int CW = 16;

  logic          CLK;
  logic          RESETn;
  logic          ARM;
  logic          CANCEL;
  logic [NS-1:0] SRC_REQ;
  logic [NS-1:0] SRC_MASK;
  logic [CW-1:0] DELAY_VAL;
  logic          RESTART_N;
  logic          BUSY;
  logic [CW-1:0] COUNT;
  logic [NS-1:0] SRC_LATCHED;

  int total = 0;
  int bad   = 0;

  isp_restart_seq #(
    .NUM_SRC(NS), .CNT_W(CW), .DEFAULT_DELAY(20), .PULSE_CYCLES(8), .HOLDOFF_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .ARM(ARM), .CANCEL(CANCEL),
    .SRC_REQ(SRC_REQ), .SRC_MASK(SRC_MASK), .DELAY_VAL(DELAY_VAL),
    .RESTART_N(RESTART_N), .BUSY(BUSY), .COUNT(COUNT), .SRC_LATCHED(SRC_LATCHED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic          arm;
    logic          cancel;
    logic [NS-1:0] req;
    logic [NS-1:0] mask;
    logic [CW-1:0] dval;
    logic          rn;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [NS-1:0] lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic arm, input logic cancel,
                     input logic [NS-1:0] req, input logic [NS-1:0] mask,
                     input logic [CW-1:0] dval, input logic rn, input logic busy,
                     input logic [CW-1:0] cnt, input logic [NS-1:0] lat);
    vec_t v;
    v.name = name; v.arm = arm; v.cancel = cancel; v.req = req; v.mask = mask;
    v.dval = dval; v.rn = rn; v.busy = busy; v.cnt = cnt; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic rn, input logic busy,
                           input logic [CW-1:0] cnt, input logic [NS-1:0] lat);
    total++;
    if ({RESTART_N, BUSY, COUNT, SRC_LATCHED} !== {rn, busy, cnt, lat}) begin
      bad++;
      $display("FAIL %s: got rn=%b busy=%b count=%0d lat=%b expected rn=%b busy=%b count=%0d lat=%b",
               name, RESTART_N, BUSY, COUNT, SRC_LATCHED, rn, busy, cnt, lat);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (BUSY && n < 40) begin
      step();
      n++;
    end
    check(name, int'(BUSY), 0);
  endtask

  initial begin
    int lows, falls, lat_seen;
    logic prev_rn;

    RESETn = 1'b0; ARM = 1'b0; CANCEL = 1'b0;
    SRC_REQ = '0; SRC_MASK = '0; DELAY_VAL = '0;

    // Table: mask filtering, cancel, hit+cancel suppression, ARM drop.
    add("mask_blk",    1, 0, 4'b0001, 4'b0010, 0, 1, 0, 0, 4'b0000);
    add("mask_rel",    1, 0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'b0000);
    add("c_hit",       1, 0, 4'b0001, 4'b0001, 5, 1, 1, 5, 4'b0001);
    add("c_d4",        1, 0, 4'b0000, 4'b0001, 5, 1, 1, 4, 4'b0001);
    add("c_d3",        1, 0, 4'b0000, 4'b0001, 5, 1, 1, 3, 4'b0001);
    add("c_cancel",    1, 1, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("c_armed",     1, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 6; i++)
      add("c_nopulse", 1, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("s_supp",      1, 1, 4'b0001, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("s_lost",      1, 0, 4'b0001, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("s_rel",       1, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("a_hit",       1, 0, 4'b0001, 4'b0001, 5, 1, 1, 5, 4'b0001);
    add("a_d4",        1, 0, 4'b0000, 4'b0001, 5, 1, 1, 4, 4'b0001);
    add("a_d3",        1, 0, 4'b0000, 4'b0001, 5, 1, 1, 3, 4'b0001);
    add("a_drop",      0, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("a_idle_hit",  0, 0, 4'b0001, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("a_idle_rel",  0, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("a_rearm_hit", 1, 0, 4'b0001, 4'b0001, 5, 1, 0, 0, 4'b0000);
    add("a_armed",     1, 0, 4'b0000, 4'b0001, 5, 1, 0, 0, 4'b0000);

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_out("reset", 1, 0, 0, 4'b0000);
    RESETn = 1'b1;

    // Basic sequence with default delay
    ARM = 1; SRC_MASK = 4'b0001; DELAY_VAL = 0;
    step();
    check_out("armed", 1, 0, 0, 4'b0000);
    SRC_REQ = 4'b0001;
    step();
    SRC_REQ = 4'b0000;
    check_out("t1_entry", 1, 1, 20, 4'b0001);
    for (int i = 19; i >= 0; i--) begin
      step();
      check_out("t1_count", 1, 1, CW'(i), 4'b0001);
    end
    step();
    check_out("t1_assert", 0, 1, 0, 4'b0001);
    for (int i = 1; i < 8; i++) begin
      step();
      check_out("t1_pulse", 0, 1, 0, 4'b0001);
    end
    step();
    check_out("t1_holdoff", 1, 1, 0, 4'b0001);
    for (int i = 1; i < 16; i++) begin
      step();
      check_out("t1_hold", 1, 1, 0, 4'b0001);
    end
    step();
    check_out("t1_done", 1, 0, 0, 4'b0000);

    // Table-driven vectors
    foreach (vecs[k]) begin
      ARM = vecs[k].arm; CANCEL = vecs[k].cancel; SRC_REQ = vecs[k].req;
      SRC_MASK = vecs[k].mask; DELAY_VAL = vecs[k].dval;
      step();
      check_out(vecs[k].name, vecs[k].rn, vecs[k].busy, vecs[k].cnt, vecs[k].lat);
    end

    // Level held 50 cycles gives exactly one sequence
    ARM = 1; CANCEL = 0; SRC_MASK = 4'b0010; DELAY_VAL = 0;
    lows = 0; falls = 0; lat_seen = 0; prev_rn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      SRC_REQ = (i < 50) ? 4'b0010 : 4'b0000;
      step();
      if (!RESTART_N) begin
        lows++;
        if (prev_rn) begin
          falls++;
          lat_seen = int'(SRC_LATCHED);
        end
      end
      prev_rn = RESTART_N;
    end
    check("hold_lows", lows, 8);
    check("hold_pulses", falls, 1);
    check("hold_lat", lat_seen, 2);
    check_out("hold_end", 1, 0, 0, 4'b0000);

    // Second hit during DELAY: no reload, OR into cause; DELAY_VAL change ignored
    SRC_MASK = 4'b0101; DELAY_VAL = 10;
    SRC_REQ = 4'b0001;
    step();
    SRC_REQ = 4'b0000;
    check_out("t4_entry", 1, 1, 10, 4'b0001);
    for (int i = 9; i >= 6; i--) begin
      step();
      check_out("t4_count", 1, 1, CW'(i), 4'b0001);
    end
    SRC_REQ = 4'b0100; DELAY_VAL = 3;
    step();
    SRC_REQ = 4'b0000;
    check_out("t4_second", 1, 1, 5, 4'b0101);
    for (int i = 4; i >= 0; i--) begin
      step();
      check_out("t4_count2", 1, 1, CW'(i), 4'b0101);
    end
    step();
    check_out("t4_pulse", 0, 1, 0, 4'b0101);
    wait_idle("t4_idle");
    check_out("t4_done", 1, 0, 0, 4'b0000);

    // Pulse immune to CANCEL/ARM/hits; holdoff ignores hits; exit to IDLE
    SRC_MASK = 4'b0001; DELAY_VAL = 1;
    SRC_REQ = 4'b0001;
    step();
    SRC_REQ = 4'b0000;
    check_out("t5_entry", 1, 1, 1, 4'b0001);
    step();
    check_out("t5_d0", 1, 1, 0, 4'b0001);
    step();
    check_out("t5_assert", 0, 1, 0, 4'b0001);
    for (int i = 1; i < 8; i++) begin
      CANCEL = i[0]; ARM = 0; SRC_REQ = i[0] ? 4'b0001 : 4'b0000;
      step();
      check_out("t5_pulse", 0, 1, 0, 4'b0001);
    end
    CANCEL = 0; ARM = 0; SRC_REQ = 4'b0000;
    step();
    check_out("t5_holdoff", 1, 1, 0, 4'b0001);
    for (int j = 1; j < 16; j++) begin
      ARM = 1; SRC_REQ = j[0] ? 4'b0001 : 4'b0000;
      step();
      check_out("t5_hold", 1, 1, 0, 4'b0001);
    end
    ARM = 0; SRC_REQ = 4'b0000;
    step();
    check_out("t5_exit", 1, 0, 0, 4'b0000);
    ARM = 1; SRC_REQ = 4'b0001;
    step();
    check_out("t5_idle_proof", 1, 0, 0, 4'b0000);
    SRC_REQ = 4'b0000;
    step();
    check_out("t5_armed", 1, 0, 0, 4'b0000);

    // Async reset mid-pulse
    SRC_REQ = 4'b0001;
    step();
    SRC_REQ = 4'b0000;
    check_out("t6_entry", 1, 1, 1, 4'b0001);
    step();
    step();
    check_out("t6_a1", 0, 1, 0, 4'b0001);
    step();
    step();
    check_out("t6_a3", 0, 1, 0, 4'b0001);
    #2;
    RESETn = 1'b0;
    #1;
    check_out("t6_async_rst", 1, 0, 0, 4'b0000);
    step();
    step();
    RESETn = 1'b1;
    check_out("t6_in_rst", 1, 0, 0, 4'b0000);
    SRC_REQ = 4'b0001;
    step();
    check_out("t6_idle_after", 1, 0, 0, 4'b0000);
    SRC_REQ = 4'b0000;
    step();
    SRC_REQ = 4'b0001;
    step();
    SRC_REQ = 4'b0000;
    check_out("t6_rearm", 1, 1, 1, 4'b0001);
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
